// File: rtl/spi_evt_reader.sv
// SPI-slave transmit side of the event path: pops one event per chip-select frame
// and shifts {valid, data[, parity]} out on MISO, MSB first. Optional: SPI_EVT_PARITY_EN.
module spi_evt_reader #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             fifo_nempty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_pop,
  input  logic             spi_csn,
  input  logic             spi_sclk,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  output logic             busy
);

`ifdef SPI_EVT_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 2;
`else
  localparam int unsigned FRAME = WIDTH + 1;
`endif
  localparam int unsigned CW = $clog2(FRAME + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state;
  logic [2:0]       csn_sync;
  logic [2:0]       sclk_sync;
  logic [FRAME-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   evt_field;
  logic [FRAME-1:0] load_word;
  logic             csn_fall;
  logic             csn_rise;
  logic             sclk_fall;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      csn_sync  <= '1;
      sclk_sync <= '0;
    end else begin
      csn_sync  <= {csn_sync[1:0], spi_csn};
      sclk_sync <= {sclk_sync[1:0], spi_sclk};
    end
  end

  assign csn_fall  = csn_sync[2] & ~csn_sync[1];
  assign csn_rise  = ~csn_sync[2] & csn_sync[1];
  assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];

  // The pop strobe is high exactly during LOAD, so it doubles as the sampled valid bit.
  assign evt_field = fifo_pop ? {1'b1, fifo_data} : '0;

`ifdef SPI_EVT_PARITY_EN
  assign load_word = {evt_field, ~^evt_field};
`else
  assign load_word = evt_field;
`endif

  // MISO is the shift register MSB; the register is zeroed whenever not shifting.
  assign spi_miso    = shreg[FRAME-1];
  assign spi_miso_oe = ~csn_sync[1];
  assign busy        = (state == LOAD) || (state == SHIFT);

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state    <= IDLE;
      fifo_pop <= 1'b0;
      shreg    <= '0;
      cnt      <= '0;
    end else begin
      fifo_pop <= 1'b0;
      case (state)
        IDLE: begin
          shreg <= '0;
          if (csn_fall) begin
            state    <= LOAD;
            fifo_pop <= fifo_nempty;
          end
        end
        LOAD: begin
          cnt <= '0;
          if (csn_rise) begin
            state <= IDLE;
            shreg <= '0;
          end else begin
            state <= SHIFT;
            shreg <= load_word;
          end
        end
        SHIFT: begin
          if (csn_rise) begin
            state <= IDLE;
            shreg <= '0;
          end else if (sclk_fall) begin
            shreg <= {shreg[FRAME-2:0], 1'b0};
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(FRAME - 1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          shreg <= '0;
          if (csn_rise) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          shreg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_evt_reader.sv
// Self-checking bench for spi_evt_reader: table of frames with a MISO scoreboard,
// plus a hand-written mid-frame reset sequence.
module tb_spi_evt_reader;

`ifdef SPI_EVT_PARITY_EN
  localparam int FR = 6;
  localparam logic [7:0] EMPTY_BITS = 8'b0000_0100;
`else
  localparam int FR = 5;
  localparam logic [7:0] EMPTY_BITS = 8'b0000_0000;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       fifo_nempty = 1'b0;
  logic [3:0] fifo_data = '0;
  logic       fifo_pop;
  logic       spi_csn;
  logic       spi_sclk;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int pop_cnt = 0;

  logic [3:0] fifo_q[$];
  logic       exp_q[$];

  spi_evt_reader #(.WIDTH(4)) dut (
    .clk(clk),
    .resetn(resetn),
    .fifo_nempty(fifo_nempty),
    .fifo_data(fifo_data),
    .fifo_pop(fifo_pop),
    .spi_csn(spi_csn),
    .spi_sclk(spi_sclk),
    .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // First-word-fall-through FIFO read port model
  always @(posedge clk) begin
    if (fifo_pop) begin
      pop_cnt++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
  end

  always @(negedge clk) begin
    fifo_nempty = (fifo_q.size() != 0);
    fifo_data   = (fifo_q.size() != 0) ? fifo_q[0] : 4'b0000;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] v);
    @(negedge clk);
    fifo_q.push_back(v);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input int ns, input logic [7:0] exp, input int exp_pops);
    int  p0;
    logic want;
    p0 = pop_cnt;
    for (int i = 0; i < ns; i++) exp_q.push_back((i < 8) ? exp[7-i] : 1'b0);
    @(negedge clk);
    spi_csn = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < ns; i++) begin
      spi_sclk = 1'b1;
      want = exp_q.pop_front();
      chk($sformatf("miso_bit%0d", i), {31'b0, spi_miso}, {31'b0, want});
      if (i == 0) begin
        chk("oe_in_frame", {31'b0, spi_miso_oe}, 32'd1);
        chk("busy_in_frame", {31'b0, busy}, {31'b0, (ns > 0)});
      end
      repeat (5) @(negedge clk);
      spi_sclk = 1'b0;
      repeat (5) @(negedge clk);
    end
    spi_csn = 1'b1;
    repeat (6) @(negedge clk);
    chk("pops_per_frame", pop_cnt - p0, exp_pops);
    chk("busy_after", {31'b0, busy}, 32'd0);
    chk("oe_after", {31'b0, spi_miso_oe}, 32'd0);
    chk("miso_after", {31'b0, spi_miso}, 32'd0);
  endtask

  typedef struct packed {
    logic [1:0]  npush;
    logic [11:0] pushes;
    logic [3:0]  nsclk;   // 0 = one full frame
    logic [7:0]  exp;     // bit 7 is the first bit sampled
    logic [1:0]  exp_pops;
  } vec_t;

  vec_t tbl[0:10];

  initial begin
    int p0;
    tbl[0]  = '{2'd0, 12'h000, 4'd0, EMPTY_BITS,   2'd0};
    tbl[1]  = '{2'd1, 12'hF00, 4'd0, 8'b1111_1000, 2'd1};
    tbl[2]  = '{2'd3, 12'hFC3, 4'd0, 8'b1111_1000, 2'd1};
    tbl[3]  = '{2'd0, 12'h000, 4'd0, 8'b1110_0000, 2'd1};
    tbl[4]  = '{2'd0, 12'h000, 4'd0, 8'b1001_1000, 2'd1};
    tbl[5]  = '{2'd0, 12'h000, 4'd0, EMPTY_BITS,   2'd0};
    tbl[6]  = '{2'd2, 12'h460, 4'd2, 8'b1000_0000, 2'd1};
    tbl[7]  = '{2'd0, 12'h000, 4'd0, 8'b1011_0000, 2'd1};
    tbl[8]  = '{2'd1, 12'h400, 4'd2, 8'b1000_0000, 2'd1};
    tbl[9]  = '{2'd0, 12'h000, 4'd0, EMPTY_BITS,   2'd0};
    tbl[10] = '{2'd1, 12'hA00, 4'd8, 8'b1101_0000, 2'd1};

    resetn   = 1'b1;
    spi_csn  = 1'b1;
    spi_sclk = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pop", {31'b0, fifo_pop}, 32'd0);
    chk("rst_miso", {31'b0, spi_miso}, 32'd0);
    chk("rst_oe", {31'b0, spi_miso_oe}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    resetn = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v <= 10; v++) begin
      logic [11:0] pv;
      pv = tbl[v].pushes;
      for (int k = 0; k < int'(tbl[v].npush); k++) push(pv[11-4*k -: 4]);
      run_frame((tbl[v].nsclk == 4'd0) ? FR : int'(tbl[v].nsclk), tbl[v].exp, int'(tbl[v].exp_pops));
    end

    // Reset asserted mid-SHIFT with 1111 queued
    p0 = pop_cnt;
    push(4'b1111);
    @(negedge clk);
    spi_csn = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      spi_sclk = 1'b1;
      chk("rstseq_miso", {31'b0, spi_miso}, 32'd1);
      repeat (5) @(negedge clk);
      spi_sclk = 1'b0;
      repeat (5) @(negedge clk);
    end
    chk("rstseq_busy_pre", {31'b0, busy}, 32'd1);
    resetn = 1'b1;
    #1;
    chk("rstseq_miso0", {31'b0, spi_miso}, 32'd0);
    chk("rstseq_oe0", {31'b0, spi_miso_oe}, 32'd0);
    chk("rstseq_busy0", {31'b0, busy}, 32'd0);
    chk("rstseq_pop0", {31'b0, fifo_pop}, 32'd0);
    spi_csn = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    repeat (6) @(negedge clk);
    chk("rstseq_pops", pop_cnt - p0, 32'd1);
    push(4'b0011);
    run_frame(FR, 8'b1001_1000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
